vga_pixel_fetch: RTL and testbench
==================================

// Module: vga_pixel_fetch
// PURPOSE
//   Upstream feeder of the VGA timing stage: fetches 32-bit framebuffer words from memory through a
//   req/ack read port, buffers them in an internal FIFO and delivers one 24-bit RGB pixel per request.
//   The timing stage pulls a pixel with pix_rd on every active (BLANK high) cycle.
//   Single pixel-clock domain.
// PARAMETERS
//   HDISP      800           active pixels per line
//   VDISP      480           active lines per frame
//   DEPTH      256           FIFO depth in pixels, power of two, >= 4
//   BASE_ADDR  32'h0000_0000 byte address of pixel (0,0)
// PORTS
//   pixel_clk    in   1   pixel clock, all logic on rising edge
//   pixel_rst_n  in   1   asynchronous active-low reset
//   mem_req      out  1   read request, held high until mem_ack
//   mem_addr     out  32  byte address of requested word, stable while mem_req high
//   mem_ack      in   1   request accepted; mem_rdata valid this cycle
//   mem_rdata    in   32  read data; pixel = mem_rdata[23:0]
//   frame_sync   in   1   1-cycle pulse: restart from BASE_ADDR (flush)
//   pix_rd       in   1   consumer pops one pixel this cycle
//   pix_valid    out  1   head pixel available (RUN state and FIFO not empty)
//   pix_data     out  24  head pixel {R,G,B}; 0 when pix_valid low
//   underflow    out  1   sticky: pix_rd seen in RUN with FIFO empty
// BEHAVIOUR
//   Reset (pixel_rst_n low, async): mem_req=0, mem_addr=BASE_ADDR, pix_valid=0, pix_data=0,
//     underflow=0, FIFO empty, word counter=0, state=PREFILL.
//   Fetch engine: at most one outstanding request. mem_req asserted when
//     count + (mem_req ? 1 : 0) < DEPTH and state != DRAIN; deasserted in the cycle after mem_ack.
//   On mem_ack: mem_rdata[23:0] written to FIFO tail (visible at head earliest next cycle);
//     mem_addr += 4; after HDISP*VDISP words mem_addr wraps to BASE_ADDR (counter wraps to 0).
//   FIFO: show-ahead; pix_data = head word combinationally from storage when pix_valid.
//     Push and pop in same cycle: count unchanged. Push when full impossible by construction.
//   FSM:
//     PREFILL: fetching, pix_valid=0, pix_rd ignored (no pop, no underflow); -> RUN when count==DEPTH.
//     RUN: pop on pix_rd & pix_valid; pix_rd with FIFO empty -> underflow<=1, nothing popped,
//       frame position NOT corrected (data stays one pixel late until next frame_sync).
//     DRAIN: entered on frame_sync from any state; FIFO flushed same edge (count=0, pix_valid=0).
//       If a request is outstanding, keep mem_req/mem_addr until mem_ack, discard that data.
//       When no request outstanding: mem_addr=BASE_ADDR, word counter=0, -> PREFILL.
//   frame_sync in DRAIN: ignored (already flushing). frame_sync and mem_ack same cycle: data discarded.
//   underflow cleared only by reset. All counters sized with $clog2; count width $clog2(DEPTH)+1.
// TESTING
//   Reset: drive pixel_rst_n=0 mid-request -> mem_req=0, mem_addr=BASE_ADDR, pix_valid=0, underflow=0.
//   Prefill, DEPTH=8, mem_ack 1 cycle after each req: exactly 8 acks, mem_addr 0..0x1C, then mem_req
//     stays 0, pix_valid=1, pix_data = word 0 [23:0].
//   Steady stream: pix_rd every cycle, 2-cycle ack latency -> first pops return words 0,1,2... in order,
//     FIFO eventually empties -> underflow=1 and stays 1.
//   Wrap, HDISP=4 VDISP=2: after 8th ack mem_addr returns to BASE_ADDR; pixel 8 equals word at BASE_ADDR.
//   frame_sync while mem_req high, ack 3 cycles later -> that word not in FIFO, next req at BASE_ADDR,
//     pix_valid low until DEPTH words refetched.
//   Simultaneous push+pop at count=DEPTH-1 in RUN -> count stays DEPTH-1, order preserved.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - framebuffer word fetcher with show-ahead pixel FIFO
// Feeds the VGA timing stage one 24-bit pixel per pix_rd, prefetching from memory ahead of the scan.
module vga_pixel_fetch #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        frame_sync,
  input  logic        pix_rd,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic        underflow
);
  localparam int unsigned NWORDS = HDISP * VDISP;
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {ST_PREFILL, ST_RUN, ST_DRAIN} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            under_q, under_d;
  logic [23:0]     fifo_mem [DEPTH];

  logic ack, sync, push, pop;
  logic unused_hi;

  assign unused_hi = ^mem_rdata[31:24];

  assign ack       = mem_ack & req_q;
  // A frame_sync while already draining is ignored; the flush is already in progress.
  assign sync      = frame_sync & (state_q != ST_DRAIN);
  assign push      = ack & ~sync & (state_q != ST_DRAIN);
  assign pix_valid = (state_q == ST_RUN) && (count_q != '0);
  assign pop       = pix_valid & pix_rd & ~sync;
  assign pix_data  = pix_valid ? fifo_mem[rd_ptr_q] : 24'h0;

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign underflow = under_q;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    under_d  = under_q;

    if (ack) begin
      req_d = 1'b0;
      if (wcnt_q == WW'(NWORDS - 1)) begin
        wcnt_d = '0;
        addr_d = BASE_ADDR;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
        addr_d = addr_q + 32'd4;
      end
    end else if (!req_q && (state_q != ST_DRAIN) && !sync && (count_q < CW'(DEPTH))) begin
      req_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Underflow does not skip a pixel: the stream stays late until the next frame_sync.
    if ((state_q == ST_RUN) && pix_rd && (count_q == '0)) under_d = 1'b1;

    case (state_q)
      ST_PREFILL: if (count_q == CW'(DEPTH)) state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      ST_DRAIN: begin
        if (!req_q) begin
          state_d = ST_PREFILL;
          addr_d  = BASE_ADDR;
          wcnt_d  = '0;
        end
      end
      default:    state_d = ST_PREFILL;
    endcase

    if (sync) begin
      state_d  = ST_DRAIN;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q  <= ST_PREFILL;
      req_q    <= 1'b0;
      addr_q   <= BASE_ADDR;
      wcnt_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wcnt_q   <= wcnt_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      under_q  <= under_d;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata[23:0];
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - scoreboard bench for vga_pixel_fetch
module tb_vga_pixel_fetch;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          NWORDS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        frame_sync = 1'b0;
  logic        pix_rd = 1'b0;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        underflow;

  int n_vec = 0;
  int n_err = 0;
  int lat = 1;
  int wcnt = 0;
  int acks = 0;
  int pushes = 0;
  int pops = 0;
  logic rd_en = 1'b0;
  logic rd_on_ack = 1'b0;
  logic discard_next = 1'b0;
  logic [31:0] exp_addr = BASE;
  logic [23:0] sb[$];

  vga_pixel_fetch #(
    .HDISP(4), .VDISP(2), .DEPTH(8), .BASE_ADDR(BASE)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .frame_sync(frame_sync), .pix_rd(pix_rd),
    .pix_valid(pix_valid), .pix_data(pix_data), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix_of(input logic [31:0] a);
    return a[23:0] ^ 24'h3C5A96;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: memory model responds, scoreboard pushes on ack and checks on pop.
  task automatic tick(input logic fs);
    logic        ack_now;
    logic [23:0] e;
    ack_now = 1'b0;
    if (mem_req) begin
      if (wcnt == lat) begin
        ack_now = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    mem_ack    = ack_now;
    mem_rdata  = ack_now ? {8'hA5, pix_of(mem_addr)} : 32'hDEAD_BEEF;
    pix_rd     = rd_en | (rd_on_ack & ack_now);
    frame_sync = fs;
    if (!pix_valid) chk("pix_data_idle", {8'h0, pix_data}, 32'h0);
    if (pix_rd && pix_valid && !fs) begin
      if (sb.size() == 0) begin
        chk("sb_underrun", {31'h0, pix_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("pix_order", {8'h0, pix_data}, {8'h0, e});
        if (pops == NWORDS) chk("wrap_pixel8", {8'h0, pix_data}, {8'h0, pix_of(BASE)});
        pops++;
      end
    end
    if (ack_now) begin
      acks++;
      if (fs) begin
      end else if (discard_next) begin
        discard_next = 1'b0;
      end else begin
        chk("ack_addr", mem_addr, exp_addr);
        sb.push_back(pix_of(mem_addr));
        pushes++;
        exp_addr = (exp_addr == BASE + 32'(4 * (NWORDS - 1))) ? BASE : exp_addr + 32'd4;
      end
    end
    if (fs) begin
      sb.delete();
      exp_addr = BASE;
      if (mem_req && !ack_now) discard_next = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    int p0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset asserted asynchronously while a request is outstanding
    lat = 6;
    tick(0); tick(0); tick(0);
    chk("req_before_reset", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_pix_valid", {31'h0, pix_valid}, 32'h0);
    chk("rst_pix_data", {8'h0, pix_data}, 32'h0);
    chk("rst_underflow", {31'h0, underflow}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ack = 1'b0;
    wcnt = 0; acks = 0; pushes = 0; pops = 0;
    discard_next = 1'b0; exp_addr = BASE;
    sb.delete();

    // Prefill: exactly DEPTH acks, address wraps after a frame of 8 words
    lat = 1;
    for (int i = 0; i < 200 && !pix_valid; i++) tick(0);
    chk("prefill_valid", {31'h0, pix_valid}, 32'h1);
    chk("prefill_acks", acks, 32'd8);
    chk("prefill_req_low", {31'h0, mem_req}, 32'h0);
    chk("prefill_addr_wrap", mem_addr, BASE);
    chk("prefill_head", {8'h0, pix_data}, {8'h0, pix_of(BASE)});
    for (int i = 0; i < 5; i++) begin
      tick(0);
      chk("full_no_req", {31'h0, mem_req}, 32'h0);
    end

    // Push and pop in the same cycle at count DEPTH-1
    rd_en = 1'b1;
    tick(0);
    rd_en = 1'b0;
    rd_on_ack = 1'b1;
    lat = 2;
    a0 = acks;
    for (int i = 0; i < 30 && acks == a0; i++) tick(0);
    chk("pushpop_ack_seen", acks, a0 + 1);
    rd_on_ack = 1'b0;
    a0 = acks;
    repeat (20) tick(0);
    chk("pushpop_refill_acks", acks, a0 + 1);
    chk("pushpop_valid", {31'h0, pix_valid}, 32'h1);

    // Steady stream outruns the fetcher until the FIFO underflows
    rd_en = 1'b1;
    for (int i = 0; i < 300 && !underflow; i++) tick(0);
    chk("underflow_set", {31'h0, underflow}, 32'h1);
    chk("wrap_reached", {31'h0, pops > NWORDS}, 32'h1);
    repeat (10) tick(0);
    chk("underflow_sticky", {31'h0, underflow}, 32'h1);

    // frame_sync with a request outstanding, ack three cycles later
    rd_en = 1'b0;
    lat = 3;
    for (int i = 0; i < 50 && mem_req; i++) tick(0);
    for (int i = 0; i < 50 && !mem_req; i++) tick(0);
    chk("sync_req_high", {31'h0, mem_req}, 32'h1);
    tick(1);
    chk("sync_flush_valid", {31'h0, pix_valid}, 32'h0);
    for (int i = 0; i < 20 && discard_next; i++) tick(0);
    chk("sync_discarded", {31'h0, discard_next}, 32'h0);
    lat = 1;
    p0 = pushes;
    for (int i = 0; i < 200 && pushes < p0 + 8; i++) begin
      tick(0);
      if (pushes < p0 + 8) chk("refetch_valid_low", {31'h0, pix_valid}, 32'h0);
    end
    chk("refetch_count", pushes, p0 + 8);
    tick(0);
    chk("refetch_valid", {31'h0, pix_valid}, 32'h1);
    chk("refetch_head", {8'h0, pix_data}, {8'h0, pix_of(BASE)});
    chk("refetch_req_low", {31'h0, mem_req}, 32'h0);
    chk("underflow_after_sync", {31'h0, underflow}, 32'h1);
    rd_en = 1'b1;
    repeat (4) tick(0);
    rd_en = 1'b0;
    tick(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
